// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO sequencer for MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
//   clk, resetn       : clock, async active-low reset
//   start, op         : launch request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b      : rs / rt operands
//   wr_hi, wr_lo      : MTHI / MTLO strobes with wdata (honoured in IDLE only)
//   flush             : abort in-flight op; also blocks start in IDLE
//   busy, done        : op in flight / one-cycle completion pulse
//   hi, lo            : architectural HI/LO registers
module muldiv_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        op_u;          // unsigned multiply
  logic [31:0] a_r;           // multiplicand, or dividend shifting into quotient
  logic [31:0] b_r;           // multiplier, or divisor magnitude
  logic [31:0] rem_r;
  logic [31:0] a_raw;         // raw dividend, returned in hi on divide by zero
  logic        q_neg, r_neg, b_zero;

  logic        accept, cnt_zero, mul_cmp, div_cmp;
  logic [32:0] rem_sh, diff;
  logic        take;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, q_fix, r_fix;
  logic        ext_a, ext_b;

  assign busy     = (state != IDLE);
  assign accept   = (state == IDLE) && start && !flush;
  assign cnt_zero = (cnt == 5'd0);
  // flush on the completing edge wins: no writeback, no done
  assign mul_cmp  = (state == MUL) && cnt_zero && !flush;
  assign div_cmp  = (state == FIX) && !flush;

  // signed divide works on magnitudes; signs are reapplied in FIX
  assign mag_a = (!op[0] && src_a[31]) ? -src_a : src_a;
  assign mag_b = (!op[0] && src_b[31]) ? -src_b : src_b;

  // one restoring step: shift rem:quot left, trial-subtract divisor
  assign rem_sh = {rem_r, a_r[31]};
  assign diff   = rem_sh - {1'b0, b_r};
  assign take   = !diff[32];

  assign q_fix = q_neg ? -a_r : a_r;
  assign r_fix = r_neg ? -rem_r : rem_r;

  // sign/zero extension to 64 bits gives the right low 64 bits for both flavours
  assign ext_a = !op_u && a_r[31];
  assign ext_b = !op_u && b_r[31];
  assign prod  = {{32{ext_a}}, a_r} * {{32{ext_b}}, b_r};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op[1] ? DIV : MUL;
      MUL:  if (flush || cnt_zero) state_nxt = IDLE;
      DIV:  if (flush) state_nxt = IDLE;
            else if (cnt_zero) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      op_u   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      rem_r  <= '0;
      a_raw  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= mul_cmp || div_cmp;

      if (accept) begin
        op_u   <= op[0];
        a_raw  <= src_a;
        b_zero <= (src_b == 32'd0);
        rem_r  <= '0;
        if (op[1]) begin
          a_r   <= mag_a;
          b_r   <= mag_b;
          q_neg <= !op[0] && (src_a[31] ^ src_b[31]);
          r_neg <= !op[0] && src_a[31];
          cnt   <= 5'd31;
        end else begin
          a_r <= src_a;
          b_r <= src_b;
          cnt <= MUL_CNT;
        end
      end else if ((state == MUL || state == DIV) && !cnt_zero) begin
        cnt <= cnt - 5'd1;
      end

      if (state == DIV) begin
        rem_r <= take ? diff[31:0] : rem_sh[31:0];
        a_r   <= {a_r[30:0], take};
      end

      if (state == IDLE) begin
        // MTHI/MTLO land even alongside start; the op result overwrites later
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end else if (mul_cmp) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end else if (div_cmp) begin
        if (b_zero) begin
          hi <= a_raw;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0, fails = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // the pipeline must never issue a HI/LO request while busy
  always @(posedge clk)
    if (resetn && busy && (start || wr_hi || wr_lo)) begin
      fails++;
      $display("FAIL illegal_req: request while busy at %0t", $time);
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain arithmetic, returns {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = 64'(sa * sb); return p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // called just after a negedge; returns cycle of done relative to accept cycle T
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_and_check(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                              input bit chk_busy);
    int lat, bcyc;
    run_op(o, a, b, lat, bcyc);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_busy) check({name, "_busy"}, 32'(bcyc), 32'(exp_lat - 1));
    check({name, "_hi"}, hi, exp[63:32]);
    check({name, "_lo"}, lo, exp[31:0]);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          elat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int saw_done, lat, bcyc;
    logic [31:0] o_hi, o_lo;
    logic [63:0] exp;
    logic [1:0]  o;
    logic [31:0] a, b;

    vecs[0] = '{2'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT + 1};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT + 1};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[3] = '{2'd3, 32'hFFFF_FFF9, 32'd2,          32'h0000_0001, 32'h7FFF_FFFC, DIV_LAT};
    vecs[4] = '{2'd3, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, DIV_LAT};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, DIV_LAT};
    vecs[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT};
    vecs[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 8; i++)
      op_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].ehi, vecs[i].elo}, vecs[i].elat, 1'b1);

    // MTHI / MTLO in IDLE
    wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi", hi, 32'hDEAD_BEEF);
    wr_lo = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo", lo, 32'h1234_5678);

    // flush mid-DIV at T+10, restart at T+11
    op = 2'd2; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    @(negedge clk);            // cycle T+1
    start = 1'b0;
    saw_done = 0;
    for (int c = 1; c < 10; c++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    flush = 1'b1;              // cycle T+10
    @(negedge clk);            // cycle T+11
    flush = 1'b0;
    if (done) saw_done++;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_no_done", 32'(saw_done), 32'd0);
    check("flush_hi", hi, 32'hDEAD_BEEF);
    check("flush_lo", lo, 32'h1234_5678);
    op_and_check("after_flush", 2'd1, 32'd5, 32'd7, 64'd35, MUL_LAT + 1, 1'b1);

    // flush coinciding with the completing MUL edge
    op = 2'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (MUL_LAT - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_cmp_done", {31'd0, done}, 32'd0);
    check("flush_cmp_busy", {31'd0, busy}, 32'd0);
    check("flush_cmp_lo", lo, 32'd35);

    // MTLO in the same cycle as start: write lands, then result overwrites
    op = 2'd0; src_a = 32'd2; src_b = 32'd3; start = 1'b1; wr_lo = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("wr_start_lo", lo, 32'hAAAA_5555);
    check("wr_start_busy", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("wr_start_lat", 32'(lat), 32'(MUL_LAT + 1));
    check("wr_start_res", lo, 32'd6);
    @(negedge clk);

    // asynchronous reset mid-DIV
    op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("arst_quiet", 32'(saw_done), 32'd0);

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 16));
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp = ref_model(o, a, b);
      op_and_check($sformatf("rnd%0d_op%0d", i, o), o, a, b, exp,
                   o[1] ? DIV_LAT : MUL_LAT + 1, 1'b0);
    end

    o_hi = hi; o_lo = lo;
    run_op(2'd1, 32'd3, 32'd4, lat, bcyc);
    check("last_busy", 32'(bcyc), 32'(MUL_LAT));
    check("last_lo", lo, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
